// File: rtl/mem_resp_pkg.sv
// Shared types for the memory responder: bus commands, tag width and the
// outstanding-load queue entry.
package mem_resp_pkg;

   localparam int TAG_W = 4;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_cmd_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      logic [CNT_W-1:0] countdown;
   } mem_resp_entry_t;

   // Tags run 1..15 and skip 0, which means "no tag" on the bus.
   function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
      return (t == '1) ? TAG_W'(1) : t + TAG_W'(1);
   endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// In-order queue of outstanding loads; every entry counts down each cycle and
// the head retires when its countdown is 1.
module mem_resp_fifo
   import mem_resp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  mem_resp_entry_t  push_entry_i,
   output logic             full_o,
   output logic             retire_o,
   output logic [TAG_W-1:0] head_tag_o,
   output logic [31:0]      head_data_o
);

   localparam int CW = $clog2(DEPTH + 1);

   mem_resp_entry_t ent_q [DEPTH];
   mem_resp_entry_t ent_d [DEPTH];
   logic [CW-1:0]   cnt_q, cnt_d;

   assign retire_o    = (cnt_q != '0) && (ent_q[0].countdown == CNT_W'(1));
   // A retiring head frees its slot for a same-cycle push.
   assign full_o      = (cnt_q == CW'(DEPTH)) && !retire_o;
   assign head_tag_o  = ent_q[0].tag;
   assign head_data_o = ent_q[0].data;

   always_comb begin
      ent_d = ent_q;
      cnt_d = cnt_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_d[i].countdown > CNT_W'(1)) begin
            ent_d[i].countdown = ent_d[i].countdown - CNT_W'(1);
         end
      end
      if (retire_o) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            ent_d[i] = ent_d[i+1];
         end
         cnt_d = cnt_q - CW'(1);
      end
      if (push_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == cnt_d) begin
               ent_d[i] = push_entry_i;
            end
         end
         cnt_d = cnt_d + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Entry payloads need no reset: only slots below cnt_q are ever observed.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      always_ff @(posedge clk) begin
         ent_q[gi] <= ent_d[gi];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Tagged memory responder with fixed load latency and bounded outstanding loads.
// Optional MEM_RESP_ALIGN_CHK_EN rejects requests whose address is not word aligned.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int MEM_WORDS = 16384,
   parameter int LATENCY   = 4,
   parameter int DEPTH     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      proc2mem_addr,
   input  logic [31:0]      proc2mem_data,
   input  logic [1:0]       proc2mem_command,
   output logic [TAG_W-1:0] mem2proc_response,
   output logic [31:0]      mem2proc_data,
   output logic [TAG_W-1:0] mem2proc_tag
);

   localparam int          AW         = $clog2(MEM_WORDS);
   localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

   logic [31:0] unified_memory [MEM_WORDS];

   logic [AW-1:0]    word_idx;
   logic [31:0]      rd_data;
   logic             is_load, is_store, addr_ok, align_ok, accept;
   logic             fifo_full, fifo_retire, fifo_push;
   logic [TAG_W-1:0] head_tag;
   logic [31:0]      head_data;
   mem_resp_entry_t  push_entry;

   logic [TAG_W-1:0] tag_ctr_q, tag_ctr_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [31:0]      data_q, data_d;

   assign word_idx = proc2mem_addr[AW+1:2];
   assign rd_data  = unified_memory[word_idx];
   assign is_load  = (proc2mem_command == BUS_LOAD);
   assign is_store = (proc2mem_command == BUS_STORE);
   assign addr_ok  = ({1'b0, proc2mem_addr} < ADDR_LIMIT);

`ifdef MEM_RESP_ALIGN_CHK_EN
   assign align_ok = (proc2mem_addr[1:0] == 2'b00);
`else
   assign align_ok = 1'b1;
`endif

   assign accept            = rst && (is_load || is_store) && addr_ok && align_ok && !fifo_full;
   assign mem2proc_response = accept ? tag_ctr_q : '0;
   assign tag_ctr_d         = accept ? next_tag(tag_ctr_q) : tag_ctr_q;

   // The acceptance cycle counts as the first latency cycle, so entries are
   // stored one count down; with LATENCY=1 the load bypasses the queue.
   assign fifo_push  = accept && is_load && (LATENCY > 1);
   assign push_entry = '{tag: tag_ctr_q, data: rd_data, countdown: CNT_W'(LATENCY - 1)};

   mem_resp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (fifo_push),
      .push_entry_i (push_entry),
      .full_o       (fifo_full),
      .retire_o     (fifo_retire),
      .head_tag_o   (head_tag),
      .head_data_o  (head_data)
   );

   always_comb begin
      tag_d  = '0;
      data_d = '0;
      if (fifo_retire) begin
         tag_d  = head_tag;
         data_d = head_data;
      end else if ((LATENCY == 1) && accept && is_load) begin
         tag_d  = tag_ctr_q;
         data_d = rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_ctr_q <= TAG_W'(1);
         tag_q     <= '0;
         data_q    <= '0;
      end else begin
         tag_ctr_q <= tag_ctr_d;
         tag_q     <= tag_d;
         data_q    <= data_d;
      end
   end

   // Storage is deliberately outside reset so preloaded contents survive it.
   always_ff @(posedge clk) begin
      if (accept && is_store) begin
         unified_memory[word_idx] <= proc2mem_data;
      end
   end

   assign mem2proc_tag  = tag_q;
   assign mem2proc_data = data_q;

endmodule
